// File: rtl/btn_event_ctrl_if.sv
// Avalon-MM slave bus for the button event controller, plus its level interrupt.
interface btn_event_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/btn_event_ctrl.sv
// Push-button controller: synchronises, debounces and sequences each button
// through press / hold / auto-repeat, latches events in an edge-capture
// register and raises a maskable level interrupt.
module btn_event_ctrl #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic               clk,
  input  logic               reset_n,
  btn_event_ctrl_if.slave    bus,
  input  logic [NUM_BTN-1:0] in_port
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_PRESSED,
    ST_REPEAT,
    ST_DB_RELEASE
  } btn_state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic [NUM_BTN-1:0] sync_p0, sync_p1;
  logic [NUM_BTN-1:0] debounced;
  logic [NUM_BTN-1:0] evt;
  logic [NUM_BTN-1:0] edgecap;
  logic [NUM_BTN-1:0] irq_mask;
  logic               repeat_en;
  logic [NUM_BTN-1:0] w1c;
  logic [31:0]        rd_mux;
  logic               wr_en;
  logic               wdata_unused;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign w1c          = (wr_en && bus.address == 2'd3) ? bus.writedata[NUM_BTN-1:0] : '0;
  assign wdata_unused = &{1'b0, bus.writedata};

  // Two-flop synchroniser on the raw button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_state_t       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;   // stable state to resume if a release bounces

    // Per-button state, counter and resume flag.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        rep_q <= rep_d;
      end
    end

    // Press / hold / repeat sequencing; a release glitch resumes the old state.
    always_comb begin
      st_d   = st_q;
      cnt_d  = sat_inc(cnt_q);
      rep_d  = rep_q;
      evt[i] = 1'b0;
      case (st_q)
        ST_IDLE: begin
          cnt_d = '0;
          rep_d = 1'b0;
          if (sync_p1[i]) st_d = ST_DB_PRESS;
        end
        ST_DB_PRESS: begin
          if (!sync_p1[i]) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else if (cnt_q >= DEB_LAST) begin
            st_d   = ST_PRESSED;
            cnt_d  = '0;
            rep_d  = 1'b0;
            evt[i] = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!sync_p1[i]) begin
            st_d  = ST_DB_RELEASE;
            cnt_d = '0;
          end else if (repeat_en && cnt_q >= HOLD_LAST) begin
            st_d   = ST_REPEAT;
            cnt_d  = '0;
            rep_d  = 1'b1;
            evt[i] = 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!sync_p1[i]) begin
            st_d  = ST_DB_RELEASE;
            cnt_d = '0;
          end else if (cnt_q >= REP_LAST) begin
            cnt_d  = '0;
            evt[i] = repeat_en;
          end
        end
        ST_DB_RELEASE: begin
          if (sync_p1[i]) begin
            st_d  = rep_q ? ST_REPEAT : ST_PRESSED;
            cnt_d = '0;
          end else if (cnt_q >= DEB_LAST) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
            rep_d = 1'b0;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
          rep_d = 1'b0;
        end
      endcase
    end

    assign debounced[i] = (st_q == ST_PRESSED) || (st_q == ST_REPEAT) ||
                          (st_q == ST_DB_RELEASE);
  end

  // Control, mask and edge-capture registers; a new event beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repeat_en <= 1'b0;
      irq_mask  <= '0;
      edgecap   <= '0;
    end else begin
      if (wr_en && bus.address == 2'd1) repeat_en <= bus.writedata[0];
      if (wr_en && bus.address == 2'd2) irq_mask  <= bus.writedata[NUM_BTN-1:0];
      edgecap <= (edgecap & ~w1c) | evt;
    end
  end

  // Read mux; unused bits are zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[NUM_BTN-1:0] = debounced;
      2'd1:    rd_mux[0]           = repeat_en;
      2'd2:    rd_mux[NUM_BTN-1:0] = irq_mask;
      default: rd_mux[NUM_BTN-1:0] = edgecap;
    endcase
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      bus.readdata <= rd_mux;
      bus.irq      <= |(edgecap & irq_mask);
    end
  end

endmodule
